// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared types and helpers for the instruction-fetch stage
//
// Purpose: fetch FSM state encoding, bus widths and PC increment helper.
// Ports: none (package).
package pc_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_ADDR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        FETCH_ST   = 2'd0,
        WAIT_ST    = 2'd1,
        DISCARD_ST = 2'd2
    } fetch_state_t;

    // Sequential PC; wraps 32'hFFFF_FFFC -> 0 by plain 32-bit overflow.
    function automatic logic [INST_ADDR_W-1:0] next_pc(input logic [INST_ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/pc_fetch_inst_queue.sv
// rtl/pc_fetch_inst_queue.sv - circular FIFO of fetched {pc, inst} pairs
//
// Purpose: buffers fetched words between memory and decode.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   push, push_pc, push_inst      enqueue one entry
//   pop                           dequeue head (ignored when empty)
//   flush_keep_none               drop every entry, including a same-cycle pop/push
//   count                         current occupancy
//   head_valid, head_pc, head_inst  oldest entry
module pc_fetch_inst_queue
    import pc_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [INST_ADDR_W-1:0]     push_pc,
    input  logic [INST_W-1:0]          push_inst,
    input  logic                       pop,
    input  logic                       flush_keep_none,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       head_valid,
    output logic [INST_ADDR_W-1:0]     head_pc,
    output logic [INST_W-1:0]          head_inst
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [INST_ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0]      inst_mem [DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic                   pop_en;

    assign head_valid = (count != '0);
    assign pop_en     = pop && head_valid;
    assign head_pc    = pc_mem[rd_ptr];
    assign head_inst  = inst_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush_keep_none) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only observed once count covers it.
    always_ff @(posedge clk) begin
        if (push && !flush_keep_none) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - RV32I instruction-fetch stage with one-outstanding memory reads
//
// Purpose: owns the fetch PC, issues word reads, queues returned words and
// presents the queue head to decode; applies decode's branch redirect.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   stall                             decode cannot accept this cycle
//   br, br_addr                       redirect from decode
//   mem_req, mem_addr, mem_gnt        request channel (combinational accept)
//   mem_rvalid, mem_rdata             in-order response channel
//   id_valid, id_pc, id_inst          queue head towards decode
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int                     QUEUE_DEPTH = 2,
    parameter logic [INST_ADDR_W-1:0] RESET_PC    = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   br,
    input  logic [INST_ADDR_W-1:0] br_addr,
    output logic                   mem_req,
    output logic [INST_ADDR_W-1:0] mem_addr,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [INST_W-1:0]      mem_rdata,
    output logic                   id_valid,
    output logic [INST_ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0]      id_inst
);

    localparam int               CNT_W    = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

    fetch_state_t           state, state_nxt;
    logic [INST_ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
    logic [INST_ADDR_W-1:0] req_pc, req_pc_nxt;

    logic [CNT_W-1:0]       q_count;
    logic                   q_valid;
    logic [INST_ADDR_W-1:0] q_pc;
    logic [INST_W-1:0]      q_inst;

    logic                   take;
    logic                   redirect;
    logic                   req_raw;
    logic                   granted;
    logic                   push;

    assign take     = q_valid && !stall;
    assign redirect = take && br;
    // Space is reserved at request time: with one outstanding read and fetch as
    // the only producer, a granted response always finds a free slot.
    assign req_raw  = (state == FETCH_ST) && (q_count < FULL_CNT);
    assign granted  = req_raw && mem_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH_ST;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_pc   <= req_pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_pc_nxt   = req_pc;
        push         = 1'b0;
        case (state)
            FETCH_ST: begin
                if (granted) begin
                    req_pc_nxt   = fetch_pc;
                    fetch_pc_nxt = next_pc(fetch_pc);
                    state_nxt    = WAIT_ST;
                end
            end
            WAIT_ST: begin
                if (mem_rvalid) begin
                    push      = !redirect;
                    state_nxt = FETCH_ST;
                end
            end
            DISCARD_ST: begin
                if (mem_rvalid) begin
                    state_nxt = FETCH_ST;
                end
            end
            default: state_nxt = FETCH_ST;
        endcase
        // A redirect wins over the sequential PC; any read still in flight
        // after this cycle belongs to the wrong path and must be dropped.
        if (redirect) begin
            fetch_pc_nxt = br_addr;
            if (state_nxt == WAIT_ST) begin
                state_nxt = DISCARD_ST;
            end
        end
    end

    pc_fetch_inst_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk             (clk),
        .rst             (rst),
        .push            (push),
        .push_pc         (req_pc),
        .push_inst       (mem_rdata),
        .pop             (take),
        .flush_keep_none (redirect),
        .count           (q_count),
        .head_valid      (q_valid),
        .head_pc         (q_pc),
        .head_inst       (q_inst)
    );

    assign mem_req  = !rst && req_raw;
    assign mem_addr = rst ? '0 : fetch_pc;
    assign id_valid = !rst && q_valid;
    assign id_pc    = id_valid ? q_pc : '0;
    assign id_inst  = id_valid ? q_inst : '0;

endmodule
